fpga_cmd_rx: RTL and testbench



---
 rtl/fpga_cmd_rx_pkg.sv | 13 +
 rtl/fpga_cmd_rx_sync_edge.sv | 30 +++
 rtl/fpga_cmd_rx.sv | 117 +++++++++++
 tb/tb_fpga_cmd_rx.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/fpga_cmd_rx_pkg.sv
// fpga_cmd_pkg: opcodes, major modes, FSM states and reset configuration for fpga_cmd_rx
package fpga_cmd_pkg;
  localparam logic [3:0] FPGA_CMD_SET_CONFREG = 4'h1;
  localparam logic [3:0] FPGA_CMD_SET_DIVISOR = 4'h2;
  localparam logic [2:0] MAJOR_MODE_0 = 3'b000;
  localparam logic [2:0] MAJOR_MODE_1 = 3'b001;
  localparam logic [2:0] MAJOR_MODE_2 = 3'b010;
  localparam logic [2:0] MAJOR_MODE_3 = 3'b011;
  localparam logic [2:0] MAJOR_MODE_4 = 3'b100;
  localparam logic [2:0] MAJOR_MODE_OFF = 3'b111;
  localparam logic [7:0] CONF_RESET = {MAJOR_MODE_OFF, 5'b0};
  typedef enum logic [1:0] {WAIT_IDLE, IDLE, SHIFT, DECODE} state_e;
endpackage

// File: rtl/fpga_cmd_rx_sync_edge.sv
// sync_edge: input synchroniser with registered rise/fall pulses; q is aligned with the pulses
module sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic nreset_i,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);
  logic [STAGES-1:0] sync_q;
  logic prev_q, rise_q, fall_q;
  always_ff @(posedge clk_i) begin
    if (!nreset_i) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      prev_q <= sync_q[STAGES-1];
      rise_q <= sync_q[STAGES-1] & ~prev_q;
      fall_q <= ~sync_q[STAGES-1] & prev_q;
    end
  end
  assign q_o = prev_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;
endmodule

// File: rtl/fpga_cmd_rx.sv
// fpga_cmd_rx: oversampled SPI command receiver driving conf_word/divisor with safe-point apply
module fpga_cmd_rx
  import fpga_cmd_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int CMD_BITS = 16,
  parameter int ERR_W = 4
) (
  input  logic ck_1356meg,
  input  logic nreset,
  input  logic spck,
  input  logic mosi,
  input  logic ncs,
  output logic miso,
  input  logic apply_en,
  output logic [7:0] conf_word,
  output logic [7:0] divisor,
  output logic cmd_strobe,
  output logic conf_pending,
  output logic [ERR_W-1:0] err_count
);
  localparam int BW = $clog2(CMD_BITS + 2);
  localparam logic [BW-1:0] BC_FULL = BW'(CMD_BITS);
  localparam logic [BW-1:0] BC_MAX = BW'(CMD_BITS + 1);
  logic spck_s, spck_rise, spck_fall, mosi_s, mosi_rise, mosi_fall, ncs_s, ncs_rise, ncs_fall;
  logic unused_edges;
  state_e state_q, state_d;
  logic [BW-1:0] bitcnt_q, bitcnt_d;
  logic [CMD_BITS-1:0] rx_q, rx_d;
  logic [15:0] tx_q, tx_d;
  logic [7:0] pend_q, pend_d, conf_q, conf_d, div_q, div_d;
  logic pending_q, pending_d, strobe_q, strobe_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic [3:0] op;
  sync_edge #(.STAGES(SYNC_STAGES)) u_spck (.clk_i(ck_1356meg), .nreset_i(nreset), .d_i(spck), .q_o(spck_s), .rise_o(spck_rise), .fall_o(spck_fall));
  sync_edge #(.STAGES(SYNC_STAGES)) u_mosi (.clk_i(ck_1356meg), .nreset_i(nreset), .d_i(mosi), .q_o(mosi_s), .rise_o(mosi_rise), .fall_o(mosi_fall));
  sync_edge #(.STAGES(SYNC_STAGES)) u_ncs (.clk_i(ck_1356meg), .nreset_i(nreset), .d_i(ncs), .q_o(ncs_s), .rise_o(ncs_rise), .fall_o(ncs_fall));
  assign unused_edges = ^{spck_s, mosi_rise, mosi_fall};
  assign op = rx_q[CMD_BITS-1 -: 4];
  always_ff @(posedge ck_1356meg) begin
    if (!nreset) begin
      state_q <= WAIT_IDLE;
      bitcnt_q <= '0;
      rx_q <= '0;
      tx_q <= '0;
      pend_q <= CONF_RESET;
      conf_q <= CONF_RESET;
      div_q <= '0;
      pending_q <= 1'b0;
      strobe_q <= 1'b0;
      err_q <= '0;
    end else begin
      state_q <= state_d;
      bitcnt_q <= bitcnt_d;
      rx_q <= rx_d;
      tx_q <= tx_d;
      pend_q <= pend_d;
      conf_q <= conf_d;
      div_q <= div_d;
      pending_q <= pending_d;
      strobe_q <= strobe_d;
      err_q <= err_d;
    end
  end
  // Apply is evaluated before decode so a fresh SET_CONFREG overrides a coincident older apply
  always_comb begin
    state_d = state_q;
    bitcnt_d = bitcnt_q;
    rx_d = rx_q;
    tx_d = tx_q;
    pend_d = pend_q;
    conf_d = conf_q;
    div_d = div_q;
    pending_d = pending_q;
    strobe_d = 1'b0;
    err_d = err_q;
    if (pending_q && apply_en) begin
      conf_d = pend_q;
      pending_d = 1'b0;
    end
    case (state_q)
      WAIT_IDLE: state_d = ncs_s ? IDLE : WAIT_IDLE;
      IDLE: if (ncs_fall) begin
        bitcnt_d = '0;
        tx_d = {conf_q, div_q};
        state_d = SHIFT;
      end
      SHIFT: begin
        if (spck_rise) begin
          rx_d = {rx_q[CMD_BITS-2:0], mosi_s};
          bitcnt_d = (bitcnt_q == BC_MAX) ? bitcnt_q : bitcnt_q + 1'b1;
        end
        if (spck_fall) tx_d = tx_q << 1;
        if (ncs_rise) state_d = DECODE;
      end
      DECODE: begin
        state_d = IDLE;
        if (bitcnt_q != BC_FULL) err_d = (err_q == '1) ? err_q : err_q + 1'b1;
        else if (op == FPGA_CMD_SET_CONFREG) begin
          pend_d = rx_q[7:0];
          pending_d = 1'b1;
          strobe_d = 1'b1;
        end else if (op == FPGA_CMD_SET_DIVISOR) begin
          div_d = rx_q[7:0];
          strobe_d = 1'b1;
        end
      end
      default: state_d = WAIT_IDLE;
    endcase
  end
  assign miso = (state_q == SHIFT) & tx_q[15];
  assign conf_word = conf_q;
  assign divisor = div_q;
  assign cmd_strobe = strobe_q;
  assign conf_pending = pending_q;
  assign err_count = err_q;
endmodule

// File: tb/tb_fpga_cmd_rx.sv
// tb_fpga_cmd_rx: randomized SPI frames checked against a frame-level configuration model
module tb_fpga_cmd_rx;
  logic clk = 1'b0, nreset = 1'b0, spck = 1'b0, mosi = 1'b0, ncs = 1'b1, apply_en = 1'b0;
  logic miso, cmd_strobe, conf_pending;
  logic [7:0] conf_word, divisor;
  logic [3:0] err_count;
  int checks = 0, errors = 0, strobes = 0, seen20 = 0;
  logic [7:0] m_conf = 8'hE0, m_div = 8'h00, m_pend = 8'h00;
  logic m_pending = 1'b0;
  int m_err = 0;

  fpga_cmd_rx dut (.ck_1356meg(clk), .nreset(nreset), .spck(spck), .mosi(mosi), .ncs(ncs), .miso(miso),
    .apply_en(apply_en), .conf_word(conf_word), .divisor(divisor), .cmd_strobe(cmd_strobe),
    .conf_pending(conf_pending), .err_count(err_count));

  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (cmd_strobe) strobes++;
    if (conf_word == 8'h20) seen20++;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic model_reset();
    m_conf = 8'hE0; m_div = 8'h00; m_pending = 1'b0; m_err = 0;
  endtask

  task automatic set_apply(input logic v);
    apply_en = v;
    wait_clk(2);
    if (m_pending && apply_en) begin m_conf = m_pend; m_pending = 1'b0; end
  endtask

  task automatic spi_bit(input logic b, output logic r);
    mosi = b;
    wait_clk(6);
    spck = 1'b1;
    r = miso;
    wait_clk(6);
    spck = 1'b0;
  endtask

  task automatic do_frame(input logic [31:0] d, input int n, output logic [31:0] rd);
    logic r;
    logic [15:0] pre;
    int s0;
    logic exp_strobe;
    pre = {m_conf, m_div};
    s0 = strobes;
    rd = '0;
    ncs = 1'b0;
    wait_clk(6);
    for (int i = n - 1; i >= 0; i--) begin
      spi_bit(d[i], r);
      rd = {rd[30:0], r};
    end
    wait_clk(6);
    ncs = 1'b1;
    wait_clk(12);
    exp_strobe = (n == 16) && (d[15:12] == 4'h1 || d[15:12] == 4'h2);
    if (n != 16) m_err = (m_err == 15) ? 15 : m_err + 1;
    else if (d[15:12] == 4'h1) begin m_pend = d[7:0]; m_pending = 1'b1; end
    else if (d[15:12] == 4'h2) m_div = d[7:0];
    if (m_pending && apply_en) begin m_conf = m_pend; m_pending = 1'b0; end
    checks++; if (conf_word !== m_conf) begin errors++; $display("FAIL frame_conf d=%h n=%0d got %h exp %h", d, n, conf_word, m_conf); end
    checks++; if (divisor !== m_div) begin errors++; $display("FAIL frame_div d=%h n=%0d got %h exp %h", d, n, divisor, m_div); end
    checks++; if (conf_pending !== m_pending) begin errors++; $display("FAIL frame_pending d=%h n=%0d got %b exp %b", d, n, conf_pending, m_pending); end
    checks++; if (err_count !== 4'(m_err)) begin errors++; $display("FAIL frame_err d=%h n=%0d got %0d exp %0d", d, n, err_count, m_err); end
    checks++; if (strobes - s0 !== int'(exp_strobe)) begin errors++; $display("FAIL frame_strobe d=%h n=%0d got %0d exp %0d", d, n, strobes - s0, exp_strobe); end
    if (n == 16) begin
      checks++; if (rd[15:0] !== pre) begin errors++; $display("FAIL frame_miso d=%h got %h exp %h", d, rd[15:0], pre); end
    end
  endtask

  task automatic test_reset();
    nreset = 1'b0;
    wait_clk(4);
    checks++; if ({conf_word, divisor, miso, cmd_strobe, conf_pending, err_count} !== {8'hE0, 8'h00, 3'b000, 4'h0}) begin
      errors++; $display("FAIL reset_values got conf=%h div=%h miso=%b stb=%b pend=%b err=%h", conf_word, divisor, miso, cmd_strobe, conf_pending, err_count);
    end
    nreset = 1'b1;
    model_reset();
    wait_clk(10);
    checks++; if (conf_word !== 8'hE0 || divisor !== 8'h00) begin errors++; $display("FAIL post_reset got conf=%h div=%h exp e0/00", conf_word, divisor); end
  endtask

  task automatic test_apply_immediate();
    logic [31:0] rd;
    set_apply(1'b1);
    do_frame(32'h1041, 16, rd);
    checks++; if (conf_word !== 8'h41 || conf_word[7:5] !== 3'b010) begin errors++; $display("FAIL apply_immediate got %h exp 41", conf_word); end
  endtask

  task automatic test_deferred();
    logic [31:0] rd;
    set_apply(1'b0);
    do_frame(32'h1023, 16, rd);
    wait_clk(50);
    checks++; if (conf_word !== 8'h41 || conf_pending !== 1'b1) begin errors++; $display("FAIL deferred_hold got conf=%h pend=%b exp 41/1", conf_word, conf_pending); end
    apply_en = 1'b1;
    @(posedge clk); #1;
    checks++; if (conf_word !== 8'h23 || conf_pending !== 1'b0) begin errors++; $display("FAIL deferred_apply got conf=%h pend=%b exp 23/0", conf_word, conf_pending); end
    m_conf = 8'h23; m_pending = 1'b0;
    wait_clk(1);
  endtask

  task automatic test_overwrite();
    logic [31:0] rd;
    int s20;
    s20 = seen20;
    set_apply(1'b0);
    do_frame(32'h1020, 16, rd);
    do_frame(32'h1060, 16, rd);
    set_apply(1'b1);
    wait_clk(2);
    checks++; if (conf_word !== 8'h60 || seen20 !== s20) begin errors++; $display("FAIL overwrite got conf=%h seen20=%0d exp 60/0", conf_word, seen20 - s20); end
  endtask

  task automatic test_errors();
    logic [31:0] rd;
    do_frame(32'h1033 >> 1, 15, rd);
    do_frame({16'h1033, 1'b1}, 17, rd);
    checks++; if (err_count !== 4'd2 || conf_word !== 8'h60) begin errors++; $display("FAIL bad_length got err=%0d conf=%h exp 2/60", err_count, conf_word); end
    do_frame(32'h7055, 16, rd);
    checks++; if (err_count !== 4'd2) begin errors++; $display("FAIL unknown_opcode got err=%0d exp 2", err_count); end
  endtask

  task automatic test_readback();
    logic [31:0] rd;
    do_frame(32'h1041, 16, rd);
    do_frame(32'h2005, 16, rd);
    do_frame(32'h7000, 16, rd);
    checks++; if (rd[15:0] !== 16'h4105) begin errors++; $display("FAIL readback got %h exp 4105", rd[15:0]); end
  endtask

  task automatic test_reset_midframe();
    logic [31:0] rd;
    logic r;
    int s0;
    logic [15:0] w;
    w = 16'h2077;
    s0 = strobes;
    ncs = 1'b0;
    wait_clk(6);
    for (int i = 15; i >= 8; i--) spi_bit(w[i], r);
    nreset = 1'b0;
    wait_clk(1);
    nreset = 1'b1;
    model_reset();
    for (int i = 7; i >= 0; i--) spi_bit(w[i], r);
    wait_clk(6);
    ncs = 1'b1;
    wait_clk(12);
    checks++; if (strobes !== s0 || divisor !== 8'h00 || err_count !== 4'h0 || conf_word !== 8'hE0) begin
      errors++; $display("FAIL midframe_reset got stb=%0d div=%h err=%0d conf=%h exp 0/00/0/e0", strobes - s0, divisor, err_count, conf_word);
    end
    do_frame(32'h2009, 16, rd);
    checks++; if (divisor !== 8'h09 || conf_word !== 8'hE0) begin errors++; $display("FAIL after_midframe got div=%h conf=%h exp 09/e0", divisor, conf_word); end
  endtask

  task automatic test_random();
    logic [31:0] rd, d;
    int n, k;
    for (int it = 0; it < 30; it++) begin
      set_apply(1'($urandom_range(0, 1)));
      k = $urandom_range(0, 9);
      d = {16'h0, 4'($urandom_range(1, 2)), 4'($urandom), 8'($urandom)};
      if (k == 0) d[15:12] = 4'($urandom);
      n = (k == 1) ? 15 : (k == 2) ? 17 : 16;
      if (n == 17) d = {d[30:0], 1'($urandom)};
      do_frame(d, n, rd);
    end
  endtask

  initial begin
    test_reset();
    test_apply_immediate();
    test_deferred();
    test_overwrite();
    test_errors();
    test_readback();
    test_reset_midframe();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
